twiddle_gen: RTL and testbench

TWIDDLE_GEN -- requirements
Module: twiddle_gen

---
 rtl/twiddle_pkg.sv | 34 +++
 rtl/twiddle_qrom.sv | 37 +++
 rtl/twiddle_gen.sv | 245 ++++++++++++++++++++++++
 tb/tb_twiddle_gen.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/twiddle_pkg.sv
// twiddle_pkg: shared constants, log2/amplitude helpers, sequencer state type
// and the elaboration-time quarter-wave cosine function for twiddle_gen.
package twiddle_pkg;

    localparam int DEF_N_POINTS = 256;
    localparam int DEF_WIDTH    = 16;
    localparam real TWO_PI      = 6.28318530717958647692;

    typedef enum logic [0:0] {
        SEQ_IDLE = 1'b0,
        SEQ_RUN  = 1'b1
    } seq_state_e;

    // Number of bits needed to index value entries (value is a power of two).
    function automatic int log2_f(input int value);
        return $clog2(value);
    endfunction

    // Unity amplitude: 2^(width-2), leaving headroom so +/-unity are both exact.
    function automatic int amp_f(input int width);
        return 32'sd1 << (width - 2);
    endfunction

    // Quarter-wave entry C[idx] = round(AMP * cos(2*pi*idx/n_points)).
    // Entries are non-negative, so the round-to-nearest cast is sign-safe.
    function automatic int cos_entry_f(input int n_points, input int width, input int idx);
        real angle;
        real scaled;
        angle  = TWO_PI * real'(idx) / real'(n_points);
        scaled = real'(amp_f(width)) * $cos(angle);
        return int'(scaled);
    endfunction

endpackage

// File: rtl/twiddle_qrom.sv
// twiddle_qrom: dual-read quarter-wave cosine table, N/4+1 entries,
// registered read with one cycle of latency; outputs hold while i_en is low.
module twiddle_qrom
    import twiddle_pkg::*;
#(
    parameter int N_POINTS = DEF_N_POINTS,
    parameter int WIDTH    = DEF_WIDTH
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_en,
    input  logic [$clog2(N_POINTS)-2:0]   i_addr_a,
    input  logic [$clog2(N_POINTS)-2:0]   i_addr_b,
    output logic [WIDTH-1:0]              o_data_a,
    output logic [WIDTH-1:0]              o_data_b
);

    localparam int QTR = N_POINTS / 4;

    logic [WIDTH-1:0] rom_s [0:QTR];

    for (genvar gi = 0; gi <= QTR; gi++) begin : g_rom
        assign rom_s[gi] = WIDTH'(cos_entry_f(N_POINTS, WIDTH, gi));
    end

    // Registered read of both table ports, frozen while the pipeline stalls
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_data_a <= {WIDTH{1'b0}};
            o_data_b <= {WIDTH{1'b0}};
        end else if (i_en) begin
            o_data_a <= rom_s[i_addr_a];
            o_data_b <= rom_s[i_addr_b];
        end
    end

endmodule

// File: rtl/twiddle_gen.sv
// twiddle_gen: FFT twiddle generator, W = exp(-j*2*pi*k/N) scaled by 2^(WIDTH-2),
// built from a quarter-wave cosine table with a 2-stage valid/ready pipeline.
// Optional build macro TWIDDLE_SEQ_EN adds a radix-2 stage address sequencer
// (i_start/i_stage, o_busy, o_last); without it those inputs are ignored and
// o_busy/o_last stay 0.
module twiddle_gen
    import twiddle_pkg::*;
#(
    parameter int N_POINTS = DEF_N_POINTS,
    parameter int WIDTH    = DEF_WIDTH
) (
    input  logic                              i_clk,
    input  logic                              i_rst_n,
    input  logic                              i_valid,
    output logic                              o_ready,
    input  logic [$clog2(N_POINTS)-1:0]       i_k,
    input  logic                              i_inverse,
    input  logic                              i_start,
    input  logic [$clog2($clog2(N_POINTS)):0] i_stage,
    output logic                              o_valid,
    input  logic                              i_ready,
    output logic signed [WIDTH-1:0]           o_real,
    output logic signed [WIDTH-1:0]           o_imag,
    output logic                              o_last,
    output logic                              o_busy
);

    localparam int KW  = log2_f(N_POINTS);
    localparam int AW  = KW - 1;
    localparam int QTR = N_POINTS / 4;

    logic                    enable_s;
    logic                    req_valid_s;
    logic                    req_inv_s;
    logic                    req_last_s;
    logic [KW-1:0]           req_k_s;
    logic                    s1_valid_r;
    logic                    s1_inv_r;
    logic                    s1_last_r;
    logic [1:0]              s1_q_r;
    logic [AW-1:0]           addr_a_s;
    logic [AW-1:0]           addr_b_s;
    logic [WIDTH-1:0]        cos_a_s;
    logic [WIDTH-1:0]        cos_b_s;
    logic signed [WIDTH-1:0] re_s;
    logic signed [WIDTH-1:0] im_s;
    logic signed [WIDTH-1:0] im_conj_s;

    // The whole pipeline moves together whenever the output slot is free.
    assign enable_s = !o_valid || i_ready;

`ifdef TWIDDLE_SEQ_EN
    localparam int            SW     = log2_f(KW) + 1;
    localparam logic [AW-1:0] J_LAST = AW'(N_POINTS / 2 - 1);

    seq_state_e    state_r;
    seq_state_e    state_next_s;
    logic [AW-1:0] j_r;
    logic [AW-1:0] j_next_s;
    logic [SW-1:0] stage_r;
    logic [SW-1:0] stage_clamp_s;
    logic          seq_inv_r;
    logic [KW-1:0] j_ext_s;
    logic [KW-1:0] mask_s;
    logic [KW-1:0] seq_k_s;

    // Clamp the requested stage to the last radix-2 stage, log2(N)-1
    always_comb begin
        if (i_stage > SW'(KW - 1)) begin
            stage_clamp_s = SW'(KW - 1);
        end else begin
            stage_clamp_s = i_stage;
        end
    end

    // Sequencer next state; j only advances when the pipeline advances
    always_comb begin
        state_next_s = state_r;
        j_next_s     = j_r;
        case (state_r)
            SEQ_IDLE: begin
                j_next_s = {AW{1'b0}};
                if (i_start) begin
                    state_next_s = SEQ_RUN;
                end else begin
                    state_next_s = SEQ_IDLE;
                end
            end
            SEQ_RUN: begin
                if (!enable_s) begin
                    state_next_s = SEQ_RUN;
                end else if (j_r == J_LAST) begin
                    state_next_s = SEQ_IDLE;
                    j_next_s     = {AW{1'b0}};
                end else begin
                    j_next_s = j_r + {{(AW-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_next_s = SEQ_IDLE;
                j_next_s     = {AW{1'b0}};
            end
        endcase
    end

    // Sequencer state, counter and run parameters captured at start
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r   <= SEQ_IDLE;
            j_r       <= {AW{1'b0}};
            stage_r   <= {SW{1'b0}};
            seq_inv_r <= 1'b0;
            o_busy    <= 1'b0;
        end else begin
            state_r <= state_next_s;
            j_r     <= j_next_s;
            o_busy  <= (state_next_s == SEQ_RUN);
            if ((state_r == SEQ_IDLE) && i_start) begin
                stage_r   <= stage_clamp_s;
                seq_inv_r <= i_inverse;
            end
        end
    end

    // Butterfly twiddle index k = (j mod 2^s) * (N >> (s+1))
    always_comb begin
        j_ext_s = {1'b0, j_r};
        mask_s  = (KW'(1'b1) << stage_r) - KW'(1'b1);
        seq_k_s = (j_ext_s & mask_s) << (SW'(KW - 1) - stage_r);
    end

    // Request source: sequencer while running, external port otherwise;
    // a start pulse in IDLE wins over a simultaneous external request
    always_comb begin
        if (state_r == SEQ_RUN) begin
            req_valid_s = 1'b1;
            req_k_s     = seq_k_s;
            req_inv_s   = seq_inv_r;
            req_last_s  = (j_r == J_LAST);
        end else begin
            req_valid_s = i_valid && !i_start;
            req_k_s     = i_k;
            req_inv_s   = i_inverse;
            req_last_s  = 1'b0;
        end
    end

    // A request that loses to i_start is not reported as accepted.
    assign o_ready = enable_s && !o_busy && !i_start;
`else
    logic unused_seq_s;

    assign unused_seq_s = ^{i_start, i_stage};
    assign req_valid_s  = i_valid;
    assign req_k_s      = i_k;
    assign req_inv_s    = i_inverse;
    assign req_last_s   = 1'b0;
    assign o_ready      = enable_s;
    assign o_busy       = 1'b0;
`endif

    // Quadrant folding: r addresses C[r], Q-r addresses the mirrored entry.
    assign addr_a_s = {1'b0, req_k_s[KW-3:0]};
    assign addr_b_s = AW'(QTR) - addr_a_s;

    twiddle_qrom #(
        .N_POINTS (N_POINTS),
        .WIDTH    (WIDTH)
    ) u_qrom (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_en     (enable_s),
        .i_addr_a (addr_a_s),
        .i_addr_b (addr_b_s),
        .o_data_a (cos_a_s),
        .o_data_b (cos_b_s)
    );

    // Stage 1: carry quadrant, conjugate flag and valid alongside the table read
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_valid_r <= 1'b0;
            s1_q_r     <= 2'd0;
            s1_inv_r   <= 1'b0;
            s1_last_r  <= 1'b0;
        end else if (enable_s) begin
            s1_valid_r <= req_valid_s;
            s1_q_r     <= req_k_s[KW-1:KW-2];
            s1_inv_r   <= req_inv_s;
            s1_last_r  <= req_valid_s && req_last_s;
        end
    end

    // Stage 2 combinational: quadrant signs, then optional conjugate.
    // Table values never exceed +AMP, so negation cannot reach the most negative code.
    always_comb begin
        re_s = {WIDTH{1'b0}};
        im_s = {WIDTH{1'b0}};
        case (s1_q_r)
            2'd0: begin
                re_s = $signed(cos_a_s);
                im_s = -$signed(cos_b_s);
            end
            2'd1: begin
                re_s = -$signed(cos_b_s);
                im_s = -$signed(cos_a_s);
            end
            2'd2: begin
                re_s = -$signed(cos_a_s);
                im_s = $signed(cos_b_s);
            end
            2'd3: begin
                re_s = $signed(cos_b_s);
                im_s = $signed(cos_a_s);
            end
            default: begin
                re_s = {WIDTH{1'b0}};
                im_s = {WIDTH{1'b0}};
            end
        endcase
        if (s1_inv_r) begin
            im_conj_s = -im_s;
        end else begin
            im_conj_s = im_s;
        end
    end

    // Stage 2 output registers, held while downstream stalls
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid <= 1'b0;
            o_last  <= 1'b0;
            o_real  <= {WIDTH{1'b0}};
            o_imag  <= {WIDTH{1'b0}};
        end else if (enable_s) begin
            o_valid <= s1_valid_r;
            o_last  <= s1_last_r;
            if (s1_valid_r) begin
                o_real <= re_s;
                o_imag <= im_conj_s;
            end
        end
    end

endmodule

// File: tb/tb_twiddle_gen.sv
// tb_twiddle_gen: scoreboard bench for twiddle_gen at N=256, WIDTH=16.
// Builds with or without TWIDDLE_SEQ_EN.
module tb_twiddle_gen;

    localparam int  N   = 256;
    localparam int  W   = 16;
    localparam int  KW  = 8;
    localparam int  SW  = 4;
    localparam int  AMP = 16384;
    localparam real PI  = 3.14159265358979323846;

    typedef struct packed {
        logic signed [31:0] re;
        logic signed [31:0] im;
        logic               last;
    } exp_t;

    logic                i_clk     = 1'b0;
    logic                i_rst_n   = 1'b0;
    logic                i_valid   = 1'b0;
    logic                o_ready;
    logic [KW-1:0]       i_k       = '0;
    logic                i_inverse = 1'b0;
    logic                i_start   = 1'b0;
    logic [SW-1:0]       i_stage   = '0;
    logic                o_valid;
    logic                i_ready   = 1'b1;
    logic signed [W-1:0] o_real;
    logic signed [W-1:0] o_imag;
    logic                o_last;
    logic                o_busy;

    int   err_cnt    = 0;
    int   chk_cnt    = 0;
    int   ready_mode = 0;
    logic mon_en     = 1'b0;
    logic hold_pend  = 1'b0;
    logic signed [W-1:0] prev_re;
    logic signed [W-1:0] prev_im;
    logic                prev_last;
    exp_t                mon_e;
    exp_t                exp_q[$];

    twiddle_gen #(
        .N_POINTS (N),
        .WIDTH    (W)
    ) dut (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_k       (i_k),
        .i_inverse (i_inverse),
        .i_start   (i_start),
        .i_stage   (i_stage),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_real    (o_real),
        .o_imag    (o_imag),
        .o_last    (o_last),
        .o_busy    (o_busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic check_eq(input string tag, input logic signed [63:0] act,
                            input logic signed [63:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d, want %0d", tag, act, exp);
        end
    endtask

    function automatic exp_t model(input int k, input logic inv, input logic last);
        exp_t e;
        real  ang;
        ang    = 2.0 * PI * real'(k) / real'(N);
        e.re   = int'(real'(AMP) * $cos(ang));
        e.im   = int'(-real'(AMP) * $sin(ang));
        if (inv) e.im = -e.im;
        e.last = last;
        return e;
    endfunction

    function automatic exp_t mk(input int re, input int im);
        exp_t e;
        e.re   = re;
        e.im   = im;
        e.last = 1'b0;
        return e;
    endfunction

    // Downstream ready pattern: 0 always ready, 1 random stalls, 2 stalled
    always @(posedge i_clk) begin
        #1;
        case (ready_mode)
            1:       i_ready = ($urandom_range(0, 3) != 0);
            2:       i_ready = 1'b0;
            default: i_ready = 1'b1;
        endcase
    end

    // Output monitor: in-order scoreboard compare and stall stability
    always @(negedge i_clk) begin
        if (!i_rst_n || !mon_en) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                check_eq("hold_valid", o_valid, 1'b1);
                check_eq("hold_real", o_real, prev_re);
                check_eq("hold_imag", o_imag, prev_im);
                check_eq("hold_last", o_last, prev_last);
            end
            if (o_valid && i_ready) begin
                check_eq("out_expected", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    check_eq("real", o_real, mon_e.re);
                    check_eq("imag", o_imag, mon_e.im);
                    check_eq("last", o_last, mon_e.last);
                end
            end
            hold_pend = o_valid && !i_ready;
            prev_re   = o_real;
            prev_im   = o_imag;
            prev_last = o_last;
        end
    end

    task automatic send(input int k, input logic inv, input exp_t e);
        logic acc;
        acc       = 1'b0;
        i_valid   = 1'b1;
        i_k       = k[KW-1:0];
        i_inverse = inv;
        for (int n = 0; n < 200 && !acc; n++) begin
            @(negedge i_clk);
            if (o_ready) begin
                exp_q.push_back(e);
                acc = 1'b1;
            end
            @(posedge i_clk);
            #1;
        end
        check_eq("send_accept", acc, 1'b1);
    endtask

    task automatic wait_drain();
        for (int n = 0; n < 3000 && exp_q.size() != 0; n++) @(negedge i_clk);
        @(negedge i_clk);
        check_eq("drain", exp_q.size(), 0);
        @(posedge i_clk);
        #1;
    endtask

    task automatic reset_mid(input string tag);
        @(posedge i_clk);
        #3;
        i_rst_n = 1'b0;
        mon_en  = 1'b0;
        #1;
        check_eq({tag, "_valid"}, o_valid, 1'b0);
        check_eq({tag, "_real"}, o_real, 0);
        check_eq({tag, "_imag"}, o_imag, 0);
        check_eq({tag, "_last"}, o_last, 1'b0);
        check_eq({tag, "_busy"}, o_busy, 1'b0);
        exp_q.delete();
        i_valid    = 1'b0;
        i_start    = 1'b0;
        ready_mode = 0;
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst_n   = 1'b1;
        mon_en    = 1'b1;
        i_valid   = 1'b1;
        i_k       = 8'd1;
        i_inverse = 1'b0;
        #1;
        check_eq({tag, "_ready"}, o_ready, 1'b1);
        exp_q.push_back(mk(16379, -402));
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        @(negedge i_clk);
        check_eq({tag, "_lat1"}, o_valid, 1'b0);
        @(negedge i_clk);
        check_eq({tag, "_lat2"}, o_valid, 1'b1);
        wait_drain();
    endtask

`ifdef TWIDDLE_SEQ_EN
    task automatic run_seq(input int stage, input logic inv, input int s_eff);
        logic done;
        int   kk;
        i_start   = 1'b1;
        i_stage   = stage[SW-1:0];
        i_inverse = inv;
        i_valid   = 1'b1;
        i_k       = 8'd5;
        @(negedge i_clk);
        check_eq("start_ready", o_ready, 1'b0);
        for (int j = 0; j < N / 2; j++) begin
            kk = (j % (1 << s_eff)) * (N >> (s_eff + 1));
            exp_q.push_back(model(kk, inv, j == N / 2 - 1));
        end
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
        i_k     = 8'd7;
        @(negedge i_clk);
        check_eq("run_busy", o_busy, 1'b1);
        done = 1'b0;
        for (int n = 0; n < 3000 && !done; n++) begin
            if (o_busy) begin
                check_eq("run_ready", o_ready, 1'b0);
                @(negedge i_clk);
            end else begin
                i_valid = 1'b0;
                done    = 1'b1;
            end
        end
        check_eq("run_end", done, 1'b1);
        wait_drain();
        check_eq("idle_busy", o_busy, 1'b0);
    endtask
`endif

    initial begin
        repeat (3) @(negedge i_clk);
        check_eq("rst_valid", o_valid, 1'b0);
        check_eq("rst_real", o_real, 0);
        check_eq("rst_imag", o_imag, 0);
        check_eq("rst_last", o_last, 1'b0);
        check_eq("rst_busy", o_busy, 1'b0);
        i_rst_n = 1'b1;
        mon_en  = 1'b1;
        @(posedge i_clk);
        #1;

        // Cardinal points back-to-back, then rounding/conjugate cases
        send(0,   1'b0, mk(16384, 0));
        send(64,  1'b0, mk(0, -16384));
        send(128, 1'b0, mk(-16384, 0));
        send(192, 1'b0, mk(0, 16384));
        send(1,   1'b0, mk(16379, -402));
        send(1,   1'b1, mk(16379, 402));
        send(255, 1'b0, mk(16379, 402));
        send(192, 1'b1, mk(0, -16384));
        i_valid = 1'b0;
        wait_drain();

        // Full sweep under random downstream stalls
        ready_mode = 1;
        for (int k = 0; k < N; k++) begin
            logic inv;
            inv = 1'($urandom_range(0, 1));
            send(k, inv, model(k, inv, 1'b0));
        end
        i_valid = 1'b0;
        wait_drain();
        ready_mode = 0;
        @(posedge i_clk);
        #2;

`ifdef TWIDDLE_SEQ_EN
        ready_mode = 1;
        run_seq(1, 1'b0, 1);
        ready_mode = 0;
        @(posedge i_clk);
        #2;
        run_seq(15, 1'b1, 7);

        // Reset in the middle of a sequencer run
        i_start = 1'b1;
        i_stage = 4'd2;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
        repeat (10) @(posedge i_clk);
        @(negedge i_clk);
        check_eq("pre_rst_busy", o_busy, 1'b1);
        reset_mid("rst_run");
`else
        // Start/stage inputs have no effect without the sequencer
        i_start = 1'b1;
        i_stage = 4'd1;
        send(3, 1'b0, model(3, 1'b0, 1'b0));
        i_start = 1'b0;
        i_valid = 1'b0;
        wait_drain();
        check_eq("noseq_busy", o_busy, 1'b0);
`endif

        // Reset while the output is stalled
        ready_mode = 2;
        @(posedge i_clk);
        #2;
        send(1, 1'b0, model(1, 1'b0, 1'b0));
        send(2, 1'b0, model(2, 1'b0, 1'b0));
        i_valid = 1'b0;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        check_eq("stall_valid", o_valid, 1'b1);
        reset_mid("rst_stall");

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", err_cnt);
        $fatal(1);
    end

endmodule
